alu_cdb_driver: RTL and testbench
=================================

Name: alu_cdb_driver

Overview:
- Execution-side counterpart of the reservation station.
- Consumes the per-cycle issue bundle the RS drives (op, Vj, Vk, rob tag, pc, imm) and evaluates the RV32I ALU/branch/jump operation.
- Queues results and drives them onto the ALU common data bus (tag + data), which the RS, ROB and LSB snoop.
- Queueing absorbs cycles in which the CDB arbiter withholds the bus.

Parameters:
- ROB_W, 4, ROB tag width; tag value 0 means "no tag".
- OP_W, 6, operation bus width; encodings are the ALU opcode set in constant.v.
- DEPTH, 4, result queue entries; power of two, ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ena  in  1  global enable; low freezes all state and ignores inputs
- clear  in  1  misprediction flush; empties the queue
- in_op  in  OP_W  issued operation; NOP = no instruction
- in_Vj  in  32  operand j
- in_Vk  in  32  operand k
- in_rob_tag  in  ROB_W  destination ROB entry
- in_pc  in  32  instruction pc
- in_imm  in  32  sign-extended immediate
- cdb_grant  in  1  arbiter grants the bus this cycle; pops the head
- cdb_valid  out  1  queue head valid
- cdb_rob_tag  out  ROB_W  head tag; 0 when not valid
- cdb_data  out  32  head result; 0 when not valid
- cdb_taken  out  1  head is a taken branch or jump
- cdb_target  out  32  head redirect target
- has_capacity  out  1  count ≤ DEPTH-2 (leaves room for one in-flight issue); to decoder stall logic

Behaviour:
- Reset: asynchronous, active-high. Queue empties; count=0; all cdb_* outputs 0; has_capacity=1; overflow flag 0.
- Push: on posedge with ena=1, clear=0 and in_op≠NOP, the computed result is written at the tail.
- The RS drives its issue bundle every cycle without handshake, so a push is never refused except on overflow.
- Compute is combinational; the queue is the only register stage. A result pushed at edge N appears on cdb_* after edge N when the queue was empty: latency 1 cycle.
- Arithmetic: 32-bit wrap-around, no overflow trap.
  - Shifts use operand[4:0].
  - SLT/SLTU write 0 or 1.
  - SRA is arithmetic.
  - I-type ops use Vj op imm.
- LUI: data=imm. AUIPC: data=pc+imm.
- JAL: data=pc+4, target=pc+imm, taken=1.
- JALR: data=pc+4, target=(Vj+imm)&~1, taken=1.
- Branches (BEQ/BNE/BLT/BGE/BLTU/BGEU): data=0, target=pc+imm, taken=compare result (signed for BLT/BGE, unsigned for BLTU/BGEU).
- Non-branch, non-jump ops: taken=0, target=0.
- Pop: posedge with ena=1, cdb_valid=1, cdb_grant=1 advances the head.
  - cdb_grant while empty is ignored.
  - Pop and push in the same edge are both performed.
  - At full with grant, push into the freed slot is legal; count is unchanged.
- Full with no grant and a push: the new result is dropped, queue unchanged.
- clear=1 at posedge (with ena=1): queue emptied, concurrent push and pop ignored; clear has priority over both.
- ena=0: no push, pop or clear takes effect; outputs hold.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- has_capacity is combinational from count.
- Reset mid-operation discards all queued results.

Optional Feature:
- Macro: ALU_OVF_CHECK_EN.
- Defined: extra output port alu_ovf_err (1 bit). It is a sticky flag set on any dropped push (full, no grant, in_op≠NOP). It is cleared only by rst, not by clear.
- Undefined: the port is absent and overflow drops are silent.

Test Plan:
- ADD, Vj=5, Vk=7, tag=3, grant held 1 → cycle after push: cdb_valid=1, tag=3, data=12, taken=0; next cycle cdb_valid=0.
- BLT, Vj=0xFFFFFFFF, Vk=1, pc=0x100, imm=8 → data=0, taken=1, target=0x108. Same operands with BLTU → taken=0.
- JALR, Vj=0x203, imm=4, pc=0x40, tag=5 → data=0x44, target=0x206, taken=1.
- Four pushes (tags 1–4) with grant=0 → count=4, has_capacity=0 after the 3rd push. Fifth push (tag 6) dropped; alu_ovf_err=1 under macro. Grant 4 cycles → tags 1,2,3,4 in order.
- Three queued entries, then clear=1 with a simultaneous push and grant → next cycle cdb_valid=0 and count=0.
- Two queued entries, rst pulsed between clock edges → cdb_valid=0 and all cdb_* outputs 0 immediately. After release, a push of ADDI Vj=1, imm=-1 broadcasts data=0.

Source files
------------

// File: rtl/alu_cdb_driver_if.sv
// Opcode set shared by the ALU CDB driver and its users, and the issue/CDB bus
// interface between the reservation station side and the ALU result queue.
package alu_cdb_pkg;
  localparam logic [5:0] OP_NOP   = 6'd0;
  localparam logic [5:0] OP_ADD   = 6'd1;
  localparam logic [5:0] OP_SUB   = 6'd2;
  localparam logic [5:0] OP_SLL   = 6'd3;
  localparam logic [5:0] OP_SLT   = 6'd4;
  localparam logic [5:0] OP_SLTU  = 6'd5;
  localparam logic [5:0] OP_XOR   = 6'd6;
  localparam logic [5:0] OP_SRL   = 6'd7;
  localparam logic [5:0] OP_SRA   = 6'd8;
  localparam logic [5:0] OP_OR    = 6'd9;
  localparam logic [5:0] OP_AND   = 6'd10;
  localparam logic [5:0] OP_ADDI  = 6'd11;
  localparam logic [5:0] OP_SLTI  = 6'd12;
  localparam logic [5:0] OP_SLTIU = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_ORI   = 6'd15;
  localparam logic [5:0] OP_ANDI  = 6'd16;
  localparam logic [5:0] OP_SLLI  = 6'd17;
  localparam logic [5:0] OP_SRLI  = 6'd18;
  localparam logic [5:0] OP_SRAI  = 6'd19;
  localparam logic [5:0] OP_LUI   = 6'd20;
  localparam logic [5:0] OP_AUIPC = 6'd21;
  localparam logic [5:0] OP_JAL   = 6'd22;
  localparam logic [5:0] OP_JALR  = 6'd23;
  localparam logic [5:0] OP_BEQ   = 6'd24;
  localparam logic [5:0] OP_BNE   = 6'd25;
  localparam logic [5:0] OP_BLT   = 6'd26;
  localparam logic [5:0] OP_BGE   = 6'd27;
  localparam logic [5:0] OP_BLTU  = 6'd28;
  localparam logic [5:0] OP_BGEU  = 6'd29;
endpackage

interface alu_cdb_if #(
  parameter int ROB_W = 4,
  parameter int OP_W  = 6
);
  logic [OP_W-1:0]  in_op;
  logic [31:0]      in_Vj;
  logic [31:0]      in_Vk;
  logic [ROB_W-1:0] in_rob_tag;
  logic [31:0]      in_pc;
  logic [31:0]      in_imm;
  logic             cdb_grant;
  logic             cdb_valid;
  logic [ROB_W-1:0] cdb_rob_tag;
  logic [31:0]      cdb_data;
  logic             cdb_taken;
  logic [31:0]      cdb_target;
  logic             has_capacity;

  modport master (
    output in_op, in_Vj, in_Vk, in_rob_tag, in_pc, in_imm, cdb_grant,
    input  cdb_valid, cdb_rob_tag, cdb_data, cdb_taken, cdb_target, has_capacity
  );

  modport slave (
    input  in_op, in_Vj, in_Vk, in_rob_tag, in_pc, in_imm, cdb_grant,
    output cdb_valid, cdb_rob_tag, cdb_data, cdb_taken, cdb_target, has_capacity
  );
endinterface

// File: rtl/alu_cdb_driver.sv
// RV32I ALU/branch evaluator feeding a result queue that drives the ALU CDB.
// Optional sticky overflow flag alu_ovf_err under `define ALU_OVF_CHECK_EN.
module alu_cdb_driver
  import alu_cdb_pkg::*;
#(
  parameter int ROB_W = 4,
  parameter int OP_W  = 6,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        clear,
`ifdef ALU_OVF_CHECK_EN
  output logic        alu_ovf_err,
`endif
  alu_cdb_if.slave    bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ROB_W-1:0] tag;
    logic [31:0]      data;
    logic             taken;
    logic [31:0]      target;
  } entry_t;

  logic [OP_W-1:0] op;
  logic [31:0]     vj, vk, pc, imm, opb;
  logic [4:0]      shamt;
  entry_t          result;

  assign op    = bus.in_op;
  assign vj    = bus.in_Vj;
  assign vk    = bus.in_Vk;
  assign pc    = bus.in_pc;
  assign imm   = bus.in_imm;
  assign shamt = opb[4:0];

  // Second ALU operand: immediate for I-type ops, Vk otherwise.
  always_comb begin
    opb = vk;
    case (op)
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
      OP_SLLI, OP_SRLI, OP_SRAI: opb = imm;
      default:                   opb = vk;
    endcase
  end

  always_comb begin
    // NOTE: every field gets a default first, so no path through the case leaves
    // a signal unassigned and no latch is inferred.
    result     = '0;
    result.tag = bus.in_rob_tag;
    case (op)
      OP_ADD,  OP_ADDI:  result.data = vj + opb;
      OP_SUB:            result.data = vj - opb;
      OP_SLL,  OP_SLLI:  result.data = vj << shamt;
      OP_SLT,  OP_SLTI:  result.data = {31'b0, $signed(vj) < $signed(opb)};
      OP_SLTU, OP_SLTIU: result.data = {31'b0, vj < opb};
      OP_XOR,  OP_XORI:  result.data = vj ^ opb;
      OP_SRL,  OP_SRLI:  result.data = vj >> shamt;
      OP_SRA,  OP_SRAI:  result.data = $signed(vj) >>> shamt;
      OP_OR,   OP_ORI:   result.data = vj | opb;
      OP_AND,  OP_ANDI:  result.data = vj & opb;
      OP_LUI:            result.data = imm;
      OP_AUIPC:          result.data = pc + imm;
      OP_JAL: begin
        result.data   = pc + 32'd4;
        result.target = pc + imm;
        result.taken  = 1'b1;
      end
      OP_JALR: begin
        result.data   = pc + 32'd4;
        result.target = (vj + imm) & ~32'd1;
        result.taken  = 1'b1;
      end
      OP_BEQ:  begin result.target = pc + imm; result.taken = (vj == vk); end
      OP_BNE:  begin result.target = pc + imm; result.taken = (vj != vk); end
      OP_BLT:  begin result.target = pc + imm; result.taken = ($signed(vj) <  $signed(vk)); end
      OP_BGE:  begin result.target = pc + imm; result.taken = ($signed(vj) >= $signed(vk)); end
      OP_BLTU: begin result.target = pc + imm; result.taken = (vj <  vk); end
      OP_BGEU: begin result.target = pc + imm; result.taken = (vj >= vk); end
      default: result.data = '0;
    endcase
  end

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             not_empty, full, push_req, pop, push;
  entry_t           head;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign push_req  = ena && !clear && (op != OP_NOP);
  assign pop       = ena && !clear && not_empty && bus.cdb_grant;
  // A full queue still accepts a push when the head leaves on the same edge.
  assign push      = push_req && (!full || pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (ena && clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = result;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read
  // when count_q marks it valid, and the outputs are zero-gated otherwise.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head             = mem_q[rd_ptr_q];
  assign bus.cdb_valid    = not_empty;
  assign bus.cdb_rob_tag  = not_empty ? head.tag    : '0;
  assign bus.cdb_data     = not_empty ? head.data   : '0;
  assign bus.cdb_taken    = not_empty ? head.taken  : 1'b0;
  assign bus.cdb_target   = not_empty ? head.target : '0;
  assign bus.has_capacity = (count_q <= CNT_W'(DEPTH - 2));

`ifdef ALU_OVF_CHECK_EN
  logic ovf_q, ovf_d;

  // Sticky until reset; a flush does not forgive a lost result.
  assign ovf_d       = ovf_q || (push_req && full && !pop);
  assign alu_ovf_err = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
`else
  // Without the checker a push into a full, ungranted queue is dropped silently.
`endif

endmodule

// File: tb/tb_alu_cdb_driver.sv
// Directed bench for alu_cdb_driver: vector table for the ALU/branch results,
// plus hand-written sequences for overflow, flush, enable and reset.
module tb_alu_cdb_driver;
  import alu_cdb_pkg::*;

  logic clk, rst, ena, clear;
`ifdef ALU_OVF_CHECK_EN
  logic alu_ovf_err;
`endif

  alu_cdb_if #(.ROB_W(4), .OP_W(6)) bus ();

  alu_cdb_driver #(.ROB_W(4), .OP_W(6), .DEPTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .clear (clear),
`ifdef ALU_OVF_CHECK_EN
    .alu_ovf_err (alu_ovf_err),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] tag);
    bus.in_op      = op;
    bus.in_Vj      = vj;
    bus.in_Vk      = vk;
    bus.in_pc      = pc;
    bus.in_imm     = imm;
    bus.in_rob_tag = tag;
  endtask

  task automatic idle();
    drive(OP_NOP, '0, '0, '0, '0, '0);
  endtask

  // Queue an ADD whose result is tag*16 so every entry is recognisable.
  task automatic push_add(input logic [3:0] tag);
    drive(OP_ADD, {24'd0, tag, 4'd0}, 32'd0, 32'd0, 32'd0, tag);
  endtask

  task automatic check_head(input string name, input logic valid, input logic [3:0] tag,
                            input logic [31:0] data);
    check({name, ".valid"}, {31'd0, bus.cdb_valid}, {31'd0, valid});
    check({name, ".tag"},   {28'd0, bus.cdb_rob_tag}, {28'd0, tag});
    check({name, ".data"},  bus.cdb_data, data);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] vj, vk, pc, imm;
    logic [3:0]  tag;
    logic [31:0] data;
    logic        taken;
    logic [31:0] target;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    vecs[0]  = '{OP_ADD,   32'd5,        32'd7,        32'h0,   32'h0,        4'd3,  32'd12,       1'b0, 32'h0};
    vecs[1]  = '{OP_SUB,   32'd3,        32'd5,        32'h0,   32'h0,        4'd4,  32'hFFFFFFFE, 1'b0, 32'h0};
    vecs[2]  = '{OP_SLL,   32'd1,        32'h21,       32'h0,   32'h0,        4'd6,  32'd2,        1'b0, 32'h0};
    vecs[3]  = '{OP_SLT,   32'hFFFFFFFF, 32'd1,        32'h0,   32'h0,        4'd7,  32'd1,        1'b0, 32'h0};
    vecs[4]  = '{OP_SLTU,  32'hFFFFFFFF, 32'd1,        32'h0,   32'h0,        4'd8,  32'd0,        1'b0, 32'h0};
    vecs[5]  = '{OP_SRA,   32'h80000000, 32'd4,        32'h0,   32'h0,        4'd9,  32'hF8000000, 1'b0, 32'h0};
    vecs[6]  = '{OP_SRL,   32'h80000000, 32'd4,        32'h0,   32'h0,        4'd10, 32'h08000000, 1'b0, 32'h0};
    vecs[7]  = '{OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0,   32'h0,        4'd11, 32'h0FF00FF0, 1'b0, 32'h0};
    vecs[8]  = '{OP_ANDI,  32'h1234,     32'hFFFF,     32'h0,   32'hFF,       4'd12, 32'h34,       1'b0, 32'h0};
    vecs[9]  = '{OP_LUI,   32'h0,        32'h0,        32'h0,   32'h12345000, 4'd13, 32'h12345000, 1'b0, 32'h0};
    vecs[10] = '{OP_AUIPC, 32'h0,        32'h0,        32'h1000, 32'h2000,    4'd14, 32'h3000,     1'b0, 32'h0};
    vecs[11] = '{OP_JAL,   32'h0,        32'h0,        32'h80,  32'h10,       4'd15, 32'h84,       1'b1, 32'h90};
    vecs[12] = '{OP_JALR,  32'h203,      32'h0,        32'h40,  32'h4,        4'd5,  32'h44,       1'b1, 32'h206};
    vecs[13] = '{OP_BLT,   32'hFFFFFFFF, 32'd1,        32'h100, 32'h8,        4'd1,  32'h0,        1'b1, 32'h108};
    vecs[14] = '{OP_BLTU,  32'hFFFFFFFF, 32'd1,        32'h100, 32'h8,        4'd2,  32'h0,        1'b0, 32'h108};
    vecs[15] = '{OP_BEQ,   32'd7,        32'd7,        32'h200, 32'hFFFFFFFC, 4'd3,  32'h0,        1'b1, 32'h1FC};
    vecs[16] = '{OP_BGEU,  32'd1,        32'hFFFFFFFF, 32'h10,  32'h20,       4'd4,  32'h0,        1'b0, 32'h30};
    vecs[17] = '{OP_SRAI,  32'hFFFFFF00, 32'd0,        32'h0,   32'h24,       4'd6,  32'hFFFFFFF0, 1'b0, 32'h0};
  end

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    clear = 1'b0;
    bus.cdb_grant = 1'b0;
    idle();

    // Reset state.
    #12;
    check_head("reset", 1'b0, 4'd0, 32'd0);
    check("reset.taken",  {31'd0, bus.cdb_taken}, 32'd0);
    check("reset.target", bus.cdb_target, 32'd0);
    check("reset.cap",    {31'd0, bus.has_capacity}, 32'd1);
`ifdef ALU_OVF_CHECK_EN
    check("reset.ovf",    {31'd0, alu_ovf_err}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back issue with grant held: each result is on the CDB for one cycle.
    bus.cdb_grant = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].op, vecs[i].vj, vecs[i].vk, vecs[i].pc, vecs[i].imm, vecs[i].tag);
      step();
      check_head($sformatf("vec%0d", i), 1'b1, vecs[i].tag, vecs[i].data);
      check($sformatf("vec%0d.taken", i),  {31'd0, bus.cdb_taken}, {31'd0, vecs[i].taken});
      check($sformatf("vec%0d.target", i), bus.cdb_target, vecs[i].target);
    end
    idle();
    step();
    check_head("drain", 1'b0, 4'd0, 32'd0);

    // Fill to full without grant, then overflow.
    bus.cdb_grant = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      push_add(4'(t));
      step();
      check($sformatf("fill%0d.cap", t), {31'd0, bus.has_capacity}, {31'd0, (t <= 2)});
    end
    push_add(4'd6);
    step();
    idle();
    check_head("full.head", 1'b1, 4'd1, 32'd16);
`ifdef ALU_OVF_CHECK_EN
    check("full.ovf", {31'd0, alu_ovf_err}, 32'd1);
`endif
    bus.cdb_grant = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      check_head($sformatf("pop%0d", t), 1'b1, 4'(t), 32'(t * 16));
      step();
    end
    check_head("pop.empty", 1'b0, 4'd0, 32'd0);
    check("pop.cap", {31'd0, bus.has_capacity}, 32'd1);

    // Full with grant: the push lands in the freed slot.
    bus.cdb_grant = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      push_add(4'(t));
      step();
    end
    bus.cdb_grant = 1'b1;
    push_add(4'd7);
    step();
    idle();
    check("swap.cap", {31'd0, bus.has_capacity}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] et;
      et = (k == 3) ? 4'd7 : 4'(k + 2);
      check_head($sformatf("swap%0d", k), 1'b1, et, {24'd0, et, 4'd0});
      step();
    end
    check_head("swap.empty", 1'b0, 4'd0, 32'd0);

    // Clear beats a concurrent push and grant.
    bus.cdb_grant = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      push_add(4'(t));
      step();
    end
    clear = 1'b1;
    bus.cdb_grant = 1'b1;
    push_add(4'd9);
    step();
    clear = 1'b0;
    idle();
    check_head("clear", 1'b0, 4'd0, 32'd0);
    check("clear.cap", {31'd0, bus.has_capacity}, 32'd1);
`ifdef ALU_OVF_CHECK_EN
    check("clear.ovf", {31'd0, alu_ovf_err}, 32'd1);
`endif
    step();
    check_head("clear.stay", 1'b0, 4'd0, 32'd0);

    // ena low freezes everything, including clear, grant and push.
    bus.cdb_grant = 1'b0;
    push_add(4'd5);
    step();
    ena = 1'b0;
    clear = 1'b1;
    bus.cdb_grant = 1'b1;
    push_add(4'd8);
    step();
    check_head("frozen", 1'b1, 4'd5, 32'h50);
    ena = 1'b1;
    clear = 1'b0;
    idle();
    step();
    check_head("thaw", 1'b0, 4'd0, 32'd0);

    // Asynchronous reset between edges discards queued entries at once.
    bus.cdb_grant = 1'b0;
    push_add(4'd1);
    step();
    push_add(4'd2);
    step();
    idle();
    #2 rst = 1'b1;
    #1;
    check_head("arst", 1'b0, 4'd0, 32'd0);
    check("arst.taken",  {31'd0, bus.cdb_taken}, 32'd0);
    check("arst.target", bus.cdb_target, 32'd0);
    check("arst.cap",    {31'd0, bus.has_capacity}, 32'd1);
`ifdef ALU_OVF_CHECK_EN
    check("arst.ovf",    {31'd0, alu_ovf_err}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    bus.cdb_grant = 1'b1;
    drive(OP_ADDI, 32'd1, 32'd0, 32'd0, 32'hFFFFFFFF, 4'd4);
    step();
    idle();
    check_head("post_rst", 1'b1, 4'd4, 32'd0);
    step();
    check_head("post_rst.empty", 1'b0, 4'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
